adc_capture_ctrl: RTL and testbench
===================================

// Module: adc_capture_ctrl
// PURPOSE
//   Triggered-capture controller for the serial 8-bit ADC sampler. Gates the sampler's
//   enable, edge-detects its sample_done level and decimates the sample stream. Waits for
//   a level-crossing (or forced) trigger, then writes a block of 2**ADDR_W consecutive
//   kept samples into an external sample RAM. Sits between the sampler and display/UART readout.
// PARAMETERS
//   DATA_W   8    sample width (matches sampler sample_data)
//   ADDR_W   8    RAM address width; capture length = 2**ADDR_W samples
//   DECIM_W  16   width of decimation ratio input
// PORTS
//   clk          in   1        system clock (single clock domain)
//   rst          in   1        synchronous reset, active-high
//   arm          in   1        1-cycle pulse: start a capture (honoured in IDLE only)
//   abort        in   1        level: cancel any capture, return to IDLE
//   force_trig   in   1        level: trigger on next kept sample regardless of level
//   trig_edge    in   1        0 = rising crossing, 1 = falling crossing
//   trig_level   in   DATA_W   trigger threshold (unsigned)
//   decim        in   DECIM_W  keep 1 of every decim+1 samples; latched on arm
//   adc_enable   out  1        drives sampler enable
//   sample_done  in   1        sampler done flag (level, held several clk)
//   sample_data  in   DATA_W   sampler data, valid while sample_done=1
//   wr_en        out  1        RAM write strobe, 1 cycle per captured sample
//   wr_addr      out  ADDR_W   RAM write address
//   wr_data      out  DATA_W   RAM write data
//   busy         out  1        high in any state other than IDLE
//   capture_done out  1        1-cycle pulse when the last sample has been written
// BEHAVIOUR
//   Reset: state=IDLE; adc_enable, wr_en, busy, capture_done = 0; wr_addr, wr_data = 0;
//     internal sd_q, decim counter, prev sample and prev_valid flag cleared. Reset dominates all inputs.
//   Sample event: new = sample_done & ~sd_q (sd_q = sample_done registered). One event per
//     sampler conversion, however long sample_done is held.
//   Decimation: down-counter loaded with latched decim on arm. Each event: counter==0 ->
//     sample kept, reload; else decrement, sample discarded. decim=0 keeps every sample.
//   States:
//     IDLE   : adc_enable=0. arm -> latch decim, prev_valid=0, go WAIT. Other inputs ignored.
//     WAIT   : adc_enable=1. On kept sample s:
//              - trigger = force_trig OR (prev_valid AND crossing), where
//                rising crossing: prev < trig_level AND s >= trig_level;
//                falling crossing: prev > trig_level AND s <= trig_level.
//              - trigger -> write s at address 0, go CAPT; else prev=s, prev_valid=1.
//              - First kept sample after arm only loads prev unless force_trig=1.
//     CAPT   : adc_enable=1. Each kept sample written at wr_addr+1. Write at address
//              2**ADDR_W-1 -> go DONE. wr_addr never wraps within one capture.
//     DONE   : one cycle; capture_done=1, adc_enable=0, -> IDLE.
//   Write timing: wr_en, wr_addr, wr_data registered; wr_en high exactly the cycle after the
//     cycle in which new=1 for a kept sample. wr_addr/wr_data hold between writes.
//   busy = (state != IDLE), registered with state.
//   abort (any non-IDLE state): next cycle state=IDLE, adc_enable=0, no capture_done,
//     pending write suppressed; RAM contents undefined for the partial block.
//   arm while busy: ignored. arm and abort same cycle in IDLE: abort wins (stay IDLE).
//   Sampler is restarted cleanly by enable low in IDLE; a sample_done edge in IDLE is discarded.
//   Comparisons unsigned, full DATA_W; no saturation or arithmetic on data.
// TESTING
//   1 Reset: rst=1 for 3 cycles mid-CAPT -> all outputs 0, state IDLE, next arm works normally.
//   2 Rising trigger, decim=0, level=0x80, samples 0x10,0x70,0x90,... -> first write 0x90 at
//     addr 0, 256 writes addr 0..255, capture_done pulse once, adc_enable drops same cycle.
//   3 Decim=3, ramp data 0,1,2,... with force_trig=1 -> writes 0,4,8,...; wr_addr n holds 4n.
//   4 Falling trigger, level=0x40: first kept sample 0x20 (no trig), 0x50, then 0x40 ->
//     trigger on 0x40; 0x20 start never triggers.
//   5 sample_done held 12 clk per conversion -> exactly one wr_en per conversion.
//   6 abort after 100 writes -> IDLE next cycle, no capture_done, no further wr_en; arm
//     during CAPT ignored (wr_addr continues unbroken).

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// Triggered-capture controller: gates the ADC sampler, decimates its samples,
// waits for a level-crossing or forced trigger, then writes one block to RAM.
module adc_capture_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DECIM_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic              trig_edge,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [DECIM_W-1:0] decim,
  output logic              adc_enable,
  input  logic              sample_done,
  input  logic [DATA_W-1:0] sample_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              capture_done
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPT,
    DONE
  } state_t;

  state_t              state;
  logic                sd_q;
  logic [DECIM_W-1:0]  decim_q;
  logic [DECIM_W-1:0]  cnt;
  logic [DATA_W-1:0]   prev;
  logic                prev_valid;

  logic                active;
  logic                new_evt;
  logic                keep;
  logic                rise_x;
  logic                fall_x;
  logic                trig;
  logic [ADDR_W-1:0]   next_addr;

  assign active    = (state == WAIT) || (state == CAPT);
  assign new_evt   = sample_done & ~sd_q;
  assign keep      = active && new_evt && (cnt == '0);
  assign rise_x    = (prev < trig_level) && (sample_data >= trig_level);
  assign fall_x    = (prev > trig_level) && (sample_data <= trig_level);
  assign trig      = force_trig | (prev_valid & (trig_edge ? fall_x : rise_x));
  assign next_addr = wr_addr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sd_q         <= 1'b0;
      decim_q      <= '0;
      cnt          <= '0;
      prev         <= '0;
      prev_valid   <= 1'b0;
      adc_enable   <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      sd_q         <= sample_done;
      wr_en        <= 1'b0;
      capture_done <= 1'b0;
      if (active && new_evt)
        cnt <= (cnt == '0) ? decim_q : cnt - 1'b1;
      if (state != IDLE && abort) begin
        state      <= IDLE;
        adc_enable <= 1'b0;
        busy       <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (arm && !abort) begin
              // first event after arm is kept; later ones every decim+1
              decim_q    <= decim;
              cnt        <= '0;
              prev_valid <= 1'b0;
              state      <= WAIT;
              adc_enable <= 1'b1;
              busy       <= 1'b1;
            end
          end
          WAIT: begin
            if (keep) begin
              if (trig) begin
                wr_en   <= 1'b1;
                wr_addr <= '0;
                wr_data <= sample_data;
                state   <= CAPT;
              end else begin
                prev       <= sample_data;
                prev_valid <= 1'b1;
              end
            end
          end
          CAPT: begin
            if (keep) begin
              wr_en   <= 1'b1;
              wr_addr <= next_addr;
              wr_data <= sample_data;
              if (next_addr == '1) begin
                state        <= DONE;
                adc_enable   <= 1'b0;
                capture_done <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: directed sample streams push
// expected RAM writes; a negedge monitor pops and compares them.
module tb_adc_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic       abort;
  logic       force_trig;
  logic       trig_edge;
  logic [7:0] trig_level;
  logic [15:0] decim;
  logic       adc_enable;
  logic       sample_done;
  logic [7:0] sample_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       capture_done;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  done_cnt = 0;
  logic [7:0] last_addr = '0;

  always #5 clk = ~clk;

  adc_capture_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .force_trig   (force_trig),
    .trig_edge    (trig_edge),
    .trig_level   (trig_level),
    .decim        (decim),
    .adc_enable   (adc_enable),
    .sample_done  (sample_done),
    .sample_data  (sample_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .capture_done (capture_done)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr %0h data %0h expected none",
                 wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, wr_addr}, {24'd0, e.a});
        check("wr_data", {24'd0, wr_data}, {24'd0, e.d});
      end
      last_addr = wr_addr;
    end
    if (capture_done) begin
      done_cnt++;
      check("done_adc_enable", {31'd0, adc_enable}, 32'd0);
      check("done_last_addr", {24'd0, last_addr}, 32'hff);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int d);
    wr_t e;
    e.a = 8'(a);
    e.d = 8'(d);
    exp_q.push_back(e);
  endtask

  task automatic conv(input logic [7:0] d, input int hold);
    sample_done = 1'b1;
    sample_data = d;
    repeat (hold) tick();
    sample_done = 1'b0;
    repeat (2) tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("busy_after_arm", {31'd0, busy}, 32'd1);
    tick();
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_adc_enable"}, {31'd0, adc_enable}, 32'd0);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_capture_done"}, {31'd0, capture_done}, 32'd0);
    check({tag, "_wr_addr"}, {24'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    arm         = 1'b0;
    abort       = 1'b0;
    force_trig  = 1'b0;
    trig_edge   = 1'b0;
    trig_level  = 8'h00;
    decim       = 16'd0;
    sample_done = 1'b0;
    sample_data = 8'h00;
    repeat (3) tick();
    check_idle_outs("reset");
    rst = 1'b0;
    tick();

    // reset in the middle of a capture
    force_trig = 1'b1;
    do_arm();
    for (int k = 0; k < 10; k++) begin
      push(k, 8'hA0 + k);
      conv(8'(8'hA0 + k), 2);
    end
    check("mid_capt_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (3) tick();
    check_idle_outs("mid_reset");
    rst        = 1'b0;
    force_trig = 1'b0;
    tick();

    // rising trigger at 0x80, no decimation
    trig_edge  = 1'b0;
    trig_level = 8'h80;
    do_arm();
    conv(8'h10, 2);
    conv(8'h70, 2);
    push(0, 8'h90);
    conv(8'h90, 2);
    for (int k = 1; k < 256; k++) begin
      push(k, k);
      conv(8'(k), 2);
    end
    conv(8'h55, 2);
    conv(8'h99, 2);
    check("rise_queue_empty", exp_q.size(), 0);
    check("rise_done_cnt", done_cnt, 1);
    check("rise_busy_end", {31'd0, busy}, 32'd0);

    // forced trigger with decim=3 on a ramp
    decim      = 16'd3;
    force_trig = 1'b1;
    do_arm();
    for (int j = 0; j < 1024; j++) begin
      if (j % 4 == 0) push(j / 4, j);
      conv(8'(j), 1);
    end
    force_trig = 1'b0;
    check("decim_queue_empty", exp_q.size(), 0);
    check("decim_done_cnt", done_cnt, 2);

    // falling trigger at 0x40 with long sample_done pulses
    decim      = 16'd0;
    trig_edge  = 1'b1;
    trig_level = 8'h40;
    do_arm();
    conv(8'h20, 12);
    conv(8'h50, 12);
    push(0, 8'h40);
    conv(8'h40, 12);
    for (int k = 1; k < 256; k++) begin
      push(k, k * 3);
      conv(8'(k * 3), 12);
    end
    check("fall_queue_empty", exp_q.size(), 0);
    check("fall_done_cnt", done_cnt, 3);

    // abort after 100 writes; arm during capture must be ignored
    trig_edge  = 1'b0;
    force_trig = 1'b1;
    do_arm();
    for (int k = 0; k < 100; k++) begin
      if (k == 50) begin
        decim = 16'd5;
        arm   = 1'b1;
        tick();
        arm = 1'b0;
      end
      push(k, 255 - k);
      conv(8'(255 - k), 2);
    end
    decim       = 16'd0;
    sample_done = 1'b1;
    sample_data = 8'h11;
    abort       = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_adc_enable", {31'd0, adc_enable}, 32'd0);
    tick();
    sample_done = 1'b0;
    tick();
    conv(8'h22, 2);
    conv(8'h33, 2);
    force_trig = 1'b0;
    check("abort_queue_empty", exp_q.size(), 0);
    check("abort_done_cnt", done_cnt, 3);

    // arm and abort together in IDLE
    arm   = 1'b1;
    abort = 1'b1;
    tick();
    arm   = 1'b0;
    abort = 1'b0;
    tick();
    check("arm_abort_idle_busy", {31'd0, busy}, 32'd0);
    check("arm_abort_idle_en", {31'd0, adc_enable}, 32'd0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
